sbus_arbiter: RTL and testbench

Bus arbiter for the serial system bus. It shares the single bus between `NUM_MASTERS` master ports and issues one-hot grants. It parks a master whose target slave port raises a split, and resumes that master with top priority when the slave signals ready. It sits in the interconnect between the master ports and the address decoder / slave-port muxes, and drives the mux select for the shared serial lines.

---
 rtl/sbus_arbiter_if.sv | 40 ++++
 rtl/sbus_arbiter.sv | 176 +++++++++++++++++
 tb/tb_sbus_arbiter.sv | 214 +++++++++++++++++++++
 3 files changed

// File: rtl/sbus_arbiter_if.sv
// -----------------------------------------------------------------------------
// sbus_arbiter_if
// Handshake bundle between the serial-bus master ports and the bus arbiter.
//   master modport : requester side (drives breq, split_en, split_done)
//   slave  modport : arbiter side   (drives bgrant, msel, bus_busy,
//                                    split_owner, timeout)
// Signals:
//   breq        per-master request, held for the whole transaction
//   split_en    addressed slave asks for a split
//   split_done  one-cycle pulse, split slave ready to resume
//   bgrant      one-hot grant (or zero)
//   msel        encoded index of granted master (0 when idle)
//   bus_busy    OR of bgrant
//   split_owner one-hot parked master (or zero)
//   timeout     one-cycle pulse when the hold watchdog revokes a grant
// -----------------------------------------------------------------------------
interface sbus_arbiter_if #(
  parameter int NUM_MASTERS = 2
);
  localparam int SEL_W = (NUM_MASTERS > 1) ? $clog2(NUM_MASTERS) : 1;

  logic [NUM_MASTERS-1:0] breq;
  logic                   split_en;
  logic                   split_done;
  logic [NUM_MASTERS-1:0] bgrant;
  logic [SEL_W-1:0]       msel;
  logic                   bus_busy;
  logic [NUM_MASTERS-1:0] split_owner;
  logic                   timeout;

  modport master (
    output breq, split_en, split_done,
    input  bgrant, msel, bus_busy, split_owner, timeout
  );

  modport slave (
    input  breq, split_en, split_done,
    output bgrant, msel, bus_busy, split_owner, timeout
  );
endinterface

// File: rtl/sbus_arbiter.sv
// -----------------------------------------------------------------------------
// sbus_arbiter
// Shares the serial system bus between NUM_MASTERS masters with one-hot
// grants. Round-robin among requesters; a master whose slave raises a split
// is parked and later resumed with top priority once split_done is seen.
// A hold watchdog (MAX_HOLD cycles, 0 = off) revokes over-long grants.
// Every grant removal is followed by one dead TURN cycle.
// Ports:
//   in_clk   bus clock, rising edge
//   reset_n  asynchronous active-low reset
//   bus      sbus_arbiter_if.slave bundle (requests in, grant/status out)
// All outputs are registered.
// -----------------------------------------------------------------------------
module sbus_arbiter #(
  parameter int NUM_MASTERS = 2,
  parameter int MAX_HOLD    = 1024
) (
  input  logic          in_clk,
  input  logic          reset_n,
  sbus_arbiter_if.slave bus
);
  localparam int SEL_W    = (NUM_MASTERS > 1) ? $clog2(NUM_MASTERS) : 1;
  localparam int HOLD_W   = (MAX_HOLD > 0) ? $clog2(MAX_HOLD + 1) : 1;
  localparam int HOLD_LIM = (MAX_HOLD > 0) ? MAX_HOLD - 1 : 0;
  localparam bit WD_EN    = (MAX_HOLD > 0);
  localparam logic [NUM_MASTERS-1:0] ONE_HOT0 = NUM_MASTERS'(1);

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_GRANTED = 2'd1,
    ST_TURN    = 2'd2
  } state_t;

  state_t                 state_q,   state_d;
  logic [NUM_MASTERS-1:0] bgrant_q,  bgrant_d;
  logic [NUM_MASTERS-1:0] owner_q,   owner_d;   // parked (split) master
  logic [SEL_W-1:0]       msel_q,    msel_d;
  logic [SEL_W-1:0]       last_q,    last_d;    // last granted index
  logic                   busy_q,    busy_d;
  logic                   resume_q,  resume_d;
  logic                   timeout_q, timeout_d;
  logic [HOLD_W-1:0]      hold_q,    hold_d;

  // Parked master is invisible to round-robin until it resumes.
  logic [NUM_MASTERS-1:0] eligible;
  logic                   resume_hit;
  assign eligible   = bus.breq & ~owner_q;
  assign resume_hit = resume_q && (|(owner_q & bus.breq));

  // Candidate index for each round-robin offset, starting after last_q.
  logic [SEL_W-1:0] cand_idx [NUM_MASTERS];
  genvar gi;
  generate
    for (gi = 0; gi < NUM_MASTERS; gi++) begin : g_cand
      assign cand_idx[gi] = SEL_W'((32'(last_q) + 32'(gi) + 32'd1) % 32'(NUM_MASTERS));
    end
  endgenerate

  logic             rr_found;
  logic [SEL_W-1:0] rr_idx;
  always_comb begin
    rr_found = 1'b0;
    rr_idx   = '0;
    // Walk from the farthest offset down so the nearest eligible one wins.
    for (int k = NUM_MASTERS - 1; k >= 0; k--) begin
      if (eligible[cand_idx[k]]) begin
        rr_found = 1'b1;
        rr_idx   = cand_idx[k];
      end
    end
  end

  logic [SEL_W-1:0] owner_idx;
  always_comb begin
    owner_idx = '0;
    for (int i = 0; i < NUM_MASTERS; i++) begin
      if (owner_q[i]) owner_idx = SEL_W'(i);
    end
  end

  always_comb begin
    state_d   = state_q;
    bgrant_d  = bgrant_q;
    owner_d   = owner_q;
    msel_d    = msel_q;
    last_d    = last_q;
    resume_d  = resume_q;
    hold_d    = hold_q;
    timeout_d = 1'b0;

    // split_done only counts while someone is parked (old owner value, so
    // a pulse in the parking cycle itself is dropped).
    if ((|owner_q) && bus.split_done) resume_d = 1'b1;

    unique case (state_q)
      ST_IDLE: begin
        if (resume_hit) begin
          state_d  = ST_GRANTED;
          bgrant_d = owner_q;
          msel_d   = owner_idx;
          last_d   = owner_idx;
          hold_d   = '0;
          owner_d  = '0;
          resume_d = 1'b0;
        end else if (rr_found) begin
          state_d  = ST_GRANTED;
          bgrant_d = ONE_HOT0 << rr_idx;
          msel_d   = rr_idx;
          last_d   = rr_idx;
          hold_d   = '0;
        end
      end
      ST_GRANTED: begin
        // Release beats split, split beats watchdog.
        if (!(|(bus.breq & bgrant_q))) begin
          state_d  = ST_TURN;
          bgrant_d = '0;
          msel_d   = '0;
        end else if (bus.split_en && !(|owner_q)) begin
          state_d  = ST_TURN;
          owner_d  = bgrant_q;
          bgrant_d = '0;
          msel_d   = '0;
        end else if (WD_EN && (hold_q == HOLD_W'(HOLD_LIM))) begin
          state_d   = ST_TURN;
          bgrant_d  = '0;
          msel_d    = '0;
          timeout_d = 1'b1;
        end else if (hold_q != '1) begin
          hold_d = hold_q + HOLD_W'(1);
        end
      end
      ST_TURN: begin
        state_d = ST_IDLE;
      end
      default: begin
        state_d  = ST_IDLE;
        bgrant_d = '0;
        msel_d   = '0;
      end
    endcase
  end

  assign busy_d = |bgrant_d;

  always_ff @(posedge in_clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q   <= ST_IDLE;
      bgrant_q  <= '0;
      owner_q   <= '0;
      msel_q    <= '0;
      last_q    <= SEL_W'(NUM_MASTERS - 1);  // master 0 is first in line
      busy_q    <= 1'b0;
      resume_q  <= 1'b0;
      timeout_q <= 1'b0;
      hold_q    <= '0;
    end else begin
      state_q   <= state_d;
      bgrant_q  <= bgrant_d;
      owner_q   <= owner_d;
      msel_q    <= msel_d;
      last_q    <= last_d;
      busy_q    <= busy_d;
      resume_q  <= resume_d;
      timeout_q <= timeout_d;
      hold_q    <= hold_d;
    end
  end

  assign bus.bgrant      = bgrant_q;
  assign bus.msel        = msel_q;
  assign bus.bus_busy    = busy_q;
  assign bus.split_owner = owner_q;
  assign bus.timeout     = timeout_q;

endmodule

// File: tb/tb_sbus_arbiter.sv
// -----------------------------------------------------------------------------
// tb_sbus_arbiter
// Drives directed sequences and random traffic into sbus_arbiter and checks
// every output each cycle against a behavioural model of the arbitration
// rules (owner / parked / dead-cycle bookkeeping in plain integers).
// -----------------------------------------------------------------------------
module tb_sbus_arbiter;
  localparam int NM = 2;
  localparam int MH = 8;

  logic in_clk  = 1'b0;
  logic reset_n = 1'b0;
  always #5 in_clk = ~in_clk;

  sbus_arbiter_if #(.NUM_MASTERS(NM)) bus ();

  sbus_arbiter #(.NUM_MASTERS(NM), .MAX_HOLD(MH)) dut (
    .in_clk  (in_clk),
    .reset_n (reset_n),
    .bus     (bus)
  );

  int n_checks = 0;
  int n_pass   = 0;
  int cyc      = 0;

  // Reference model state: -1 means "nobody".
  int m_owner;
  int m_parked;
  int m_last;
  int m_held;
  bit m_turn;
  bit m_resume;
  bit m_tmo;

  int rem [NM];

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s cycle %0d: got %0h expected %0h", tag, cyc, got, exp);
  endtask

  task automatic model_reset();
    m_owner  = -1;
    m_parked = -1;
    m_last   = NM - 1;
    m_held   = 0;
    m_turn   = 0;
    m_resume = 0;
    m_tmo    = 0;
  endtask

  // One clock edge of the arbiter, given the inputs present at that edge.
  task automatic model_step(input logic [NM-1:0] b, input logic se, input logic sd);
    bit take;
    bit cleared;
    take    = (m_parked >= 0) && sd;
    cleared = 0;
    m_tmo   = 0;
    if (m_owner >= 0) begin
      if (!b[m_owner]) begin
        m_owner = -1; m_turn = 1;
      end else if (se && m_parked < 0) begin
        m_parked = m_owner; m_owner = -1; m_turn = 1;
      end else if (m_held == MH - 1) begin
        m_tmo = 1; m_owner = -1; m_turn = 1;
      end else begin
        m_held++;
      end
    end else if (m_turn) begin
      m_turn = 0;
    end else begin
      if (m_resume && m_parked >= 0 && b[m_parked]) begin
        m_owner  = m_parked;
        m_parked = -1;
        m_resume = 0;
        cleared  = 1;
      end else begin
        for (int k = 1; k <= NM; k++) begin
          int i;
          i = (m_last + k) % NM;
          if (m_owner < 0 && b[i] && i != m_parked) m_owner = i;
        end
      end
      if (m_owner >= 0) begin
        m_last = m_owner;
        m_held = 0;
        $display("cycle %0d: grant master %0d%s", cyc, m_owner, cleared ? " (resumed split)" : "");
      end
    end
    if (take && !cleared) m_resume = 1;
  endtask

  task automatic compare_all();
    logic [NM-1:0] exp_g;
    logic [NM-1:0] exp_s;
    exp_g = (m_owner  >= 0) ? NM'(1) << m_owner  : '0;
    exp_s = (m_parked >= 0) ? NM'(1) << m_parked : '0;
    check_eq("bgrant",      32'(bus.bgrant),      32'(exp_g));
    check_eq("msel",        32'(bus.msel),        (m_owner >= 0) ? 32'(m_owner) : 32'd0);
    check_eq("bus_busy",    32'(bus.bus_busy),    32'(m_owner >= 0));
    check_eq("split_owner", 32'(bus.split_owner), 32'(exp_s));
    check_eq("timeout",     32'(bus.timeout),     32'(m_tmo));
  endtask

  task automatic cycle();
    @(posedge in_clk);
    #1;
    cyc++;
    model_step(bus.breq, bus.split_en, bus.split_done);
    compare_all();
  endtask

  task automatic step(input logic [NM-1:0] b, input logic se, input logic sd, input int n);
    bus.breq       = b;
    bus.split_en   = se;
    bus.split_done = sd;
    repeat (n) cycle();
  endtask

  // Per-cycle traffic generator; decisions use the model's view of grants.
  task automatic auto_drive(input int p_req, input int len_lo, input int len_hi,
                            input int p_split, input int p_done, input int p_drop);
    for (int i = 0; i < NM; i++) begin
      if (!bus.breq[i]) begin
        if (int'($urandom_range(99)) < p_req) begin
          bus.breq[i] = 1'b1;
          rem[i] = int'($urandom_range(len_hi, len_lo));
        end
      end else if (m_owner == i) begin
        rem[i]--;
        if (rem[i] <= 0) bus.breq[i] = 1'b0;
      end else if (int'($urandom_range(99)) < p_drop) begin
        bus.breq[i] = 1'b0;
      end
    end
    bus.split_en   = (int'($urandom_range(99)) < p_split);
    bus.split_done = (int'($urandom_range(99)) < p_done);
  endtask

  task automatic run_auto(input int n, input int p_req, input int len_lo, input int len_hi,
                          input int p_split, input int p_done, input int p_drop);
    step('0, 1'b0, 1'b0, 4);
    for (int i = 0; i < NM; i++) rem[i] = 0;
    repeat (n) begin
      auto_drive(p_req, len_lo, len_hi, p_split, p_done, p_drop);
      cycle();
    end
  endtask

  initial begin
    bus.breq       = '0;
    bus.split_en   = 1'b0;
    bus.split_done = 1'b0;
    model_reset();
    repeat (3) @(posedge in_clk);
    #1;
    compare_all();                       // reset values
    reset_n = 1'b1;

    // Single master request and release.
    step(2'b00, 0, 0, 2);
    step(2'b01, 0, 0, 4);
    step(2'b00, 0, 0, 4);

    // Round-robin, both masters always requesting, short transactions.
    run_auto(60, 100, 4, 4, 0, 0, 0);

    // Split park, resume after another master, second split ignored.
    step(2'b00, 0, 0, 3);
    step(2'b01, 0, 0, 2);
    step(2'b01, 1, 0, 1);
    step(2'b11, 0, 0, 3);
    step(2'b11, 0, 1, 1);
    step(2'b11, 1, 0, 1);
    step(2'b11, 0, 0, 2);
    step(2'b01, 0, 0, 4);
    step(2'b00, 0, 0, 3);

    // Watchdog: split coincident with expiry parks, then a plain timeout.
    step(2'b10, 0, 0, 8);
    step(2'b10, 1, 0, 1);
    step(2'b00, 0, 1, 1);
    step(2'b10, 0, 0, 12);
    step(2'b00, 0, 0, 3);

    // Random traffic.
    run_auto(3000, 30, 1, 12, 10, 10, 3);

    // Reset while one master is granted and the other is parked.
    step(2'b00, 0, 0, 3);
    step(2'b01, 0, 0, 2);
    step(2'b01, 1, 0, 1);
    step(2'b11, 0, 0, 4);
    #3;
    reset_n = 1'b0;
    #1;
    check_eq("rst_bgrant",      32'(bus.bgrant),      32'd0);
    check_eq("rst_msel",        32'(bus.msel),        32'd0);
    check_eq("rst_bus_busy",    32'(bus.bus_busy),    32'd0);
    check_eq("rst_split_owner", 32'(bus.split_owner), 32'd0);
    check_eq("rst_timeout",     32'(bus.timeout),     32'd0);
    model_reset();
    @(posedge in_clk);
    #1;
    reset_n = 1'b1;
    step(2'b11, 0, 0, 3);
    step(2'b00, 0, 0, 3);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end
endmodule
